// File: rtl/eth_crc_pkg.sv
// rtl/eth_crc_pkg.sv - Ethernet CRC-32 constants, state type and bit-serial update helpers
package eth_crc_pkg;

    localparam logic [32:0] ETH_CRC_POLY    = 33'h104C11DB7;
    localparam logic [31:0] ETH_CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] ETH_CRC_RESIDUE = 32'hC704DD7B;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_IN_FRAME = 1'b1
    } fsm_state_e;

    // Raw (non-reflected) register, byte fed LSB first as it appears on the wire
    function automatic logic [31:0] crc32_byte_update(input logic [31:0] crc,
                                                      input logic [7:0]  data_byte,
                                                      input logic [31:0] poly);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            fb = c[31] ^ data_byte[i];
            c  = {c[30:0], 1'b0} ^ (fb ? poly : 32'h0);
        end
        return c;
    endfunction

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/ethernet_crc32_lanes.sv
// rtl/ethernet_crc32_lanes.sv - combinational multi-byte CRC-32 update, byte chain gated by keep
module ethernet_crc32_lanes
    import eth_crc_pkg::*;
#(
    parameter int          DATA_BYTES = 4,
    parameter logic [31:0] POLY       = ETH_CRC_POLY[31:0]
) (
    input  logic [31:0]             crc_in,
    input  logic [8*DATA_BYTES-1:0] data,
    input  logic [DATA_BYTES-1:0]   keep,
    output logic [31:0]             crc_out
);

    logic [31:0] chain [DATA_BYTES+1];

    assign chain[0] = crc_in;

    // Keep is contiguous from lane 0, so a disabled lane simply passes the register through
    for (genvar i = 0; i < DATA_BYTES; i++) begin : g_lane
        assign chain[i+1] = keep[i] ? crc32_byte_update(chain[i], data[8*i +: 8], POLY)
                                    : chain[i];
    end

    assign crc_out = chain[DATA_BYTES];

endmodule

// File: rtl/ethernet_crc32_stream.sv
// rtl/ethernet_crc32_stream.sv - framed multi-byte Ethernet CRC-32 with FCS generation and residue check
module ethernet_crc32_stream
    import eth_crc_pkg::*;
#(
    parameter int          DATA_BYTES = 4,
    parameter logic [32:0] POLYNOMIAL = ETH_CRC_POLY,
    parameter logic [31:0] INIT       = ETH_CRC_INIT,
    parameter logic [31:0] RESIDUE    = ETH_CRC_RESIDUE
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic                    in_sop,
    input  logic                    in_eop,
    input  logic [8*DATA_BYTES-1:0] in_data,
    input  logic [DATA_BYTES-1:0]   in_keep,
    output logic [31:0]             crc_state,
    output logic                    out_valid,
    output logic [31:0]             fcs_out,
    output logic                    fcs_ok,
    output logic                    err
);

    localparam logic [DATA_BYTES-1:0] KEEP_ONE = DATA_BYTES'(1);

    fsm_state_e            state, state_next;
    logic [31:0]           crc_base, lane_crc, crc_next;
    logic [DATA_BYTES-1:0] keep_plus;
    logic                  keep_full, keep_eop_ok, beat_ok;
    logic                  out_valid_next, err_next;

    // A sop beat always restarts from INIT, even when it aborts a running frame
    assign crc_base = in_sop ? INIT : crc_state;

    ethernet_crc32_lanes #(
        .DATA_BYTES (DATA_BYTES),
        .POLY       (POLYNOMIAL[31:0])
    ) u_lanes (
        .crc_in  (crc_base),
        .data    (in_data),
        .keep    (in_keep),
        .crc_out (lane_crc)
    );

    assign keep_plus   = in_keep + KEEP_ONE;
    assign keep_full   = &in_keep;
    assign keep_eop_ok = (|in_keep) && ((in_keep & keep_plus) == '0);
    assign beat_ok     = in_eop ? keep_eop_ok : keep_full;

    always_comb begin
        state_next     = state;
        crc_next       = crc_state;
        out_valid_next = 1'b0;
        err_next       = 1'b0;
        if (in_valid) begin
            if (state == ST_IDLE && !in_sop) begin
                err_next = 1'b1;
            end else begin
                err_next = (state == ST_IN_FRAME) && in_sop;
                if (!beat_ok) begin
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                    crc_next   = INIT;
                end else begin
                    crc_next = lane_crc;
                    if (in_eop) begin
                        state_next     = ST_IDLE;
                        out_valid_next = 1'b1;
                    end else begin
                        state_next = ST_IN_FRAME;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            crc_state <= INIT;
            out_valid <= 1'b0;
            fcs_out   <= 32'h0;
            fcs_ok    <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_next;
            crc_state <= crc_next;
            out_valid <= out_valid_next;
            err       <= err_next;
            if (out_valid_next) begin
                fcs_out <= ~bitrev32(lane_crc);
                fcs_ok  <= (lane_crc == RESIDUE);
            end
        end
    end

endmodule

// File: tb/tb_ethernet_crc32_stream.sv
// tb/tb_ethernet_crc32_stream.sv - self-checking bench for ethernet_crc32_stream at 1/2/4/8 bytes per beat
module tb_ethernet_crc32_stream;

    localparam int NL = 4;

    typedef struct {
        int          lane;
        int          len;
        bit          append;
        bit          flip;
        bit          use_const;
        logic [31:0] c_fcs;
        logic        c_ok;
    } vec_t;

    typedef struct {
        int          lane;
        logic [31:0] fcs;
        logic        ok;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [NL-1:0] v = '0, sop = '0, eop = '0;
    logic [7:0]  d0 = '0;
    logic [0:0]  k0 = '0;
    logic [15:0] d1 = '0;
    logic [1:0]  k1 = '0;
    logic [31:0] d2 = '0;
    logic [3:0]  k2 = '0;
    logic [63:0] d3 = '0;
    logic [7:0]  k3 = '0;
    logic [NL-1:0][31:0] o_crc, o_fcs;
    logic [NL-1:0]       o_valid, o_ok, o_err;

    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    int   ov_last = 0;
    int   ov_prev = 0;
    int   err_seen [NL];
    exp_t sb [$];
    exp_t mon_e;
    vec_t vecs [$];

    always #5 clk = ~clk;

    ethernet_crc32_stream #(.DATA_BYTES(1)) dut_w1 (
        .clk(clk), .reset(reset), .in_valid(v[0]), .in_sop(sop[0]), .in_eop(eop[0]),
        .in_data(d0), .in_keep(k0), .crc_state(o_crc[0]), .out_valid(o_valid[0]),
        .fcs_out(o_fcs[0]), .fcs_ok(o_ok[0]), .err(o_err[0]));
    ethernet_crc32_stream #(.DATA_BYTES(2)) dut_w2 (
        .clk(clk), .reset(reset), .in_valid(v[1]), .in_sop(sop[1]), .in_eop(eop[1]),
        .in_data(d1), .in_keep(k1), .crc_state(o_crc[1]), .out_valid(o_valid[1]),
        .fcs_out(o_fcs[1]), .fcs_ok(o_ok[1]), .err(o_err[1]));
    ethernet_crc32_stream #(.DATA_BYTES(4)) dut_w4 (
        .clk(clk), .reset(reset), .in_valid(v[2]), .in_sop(sop[2]), .in_eop(eop[2]),
        .in_data(d2), .in_keep(k2), .crc_state(o_crc[2]), .out_valid(o_valid[2]),
        .fcs_out(o_fcs[2]), .fcs_ok(o_ok[2]), .err(o_err[2]));
    ethernet_crc32_stream #(.DATA_BYTES(8)) dut_w8 (
        .clk(clk), .reset(reset), .in_valid(v[3]), .in_sop(sop[3]), .in_eop(eop[3]),
        .in_data(d3), .in_keep(k3), .crc_state(o_crc[3]), .out_valid(o_valid[3]),
        .fcs_out(o_fcs[3]), .fcs_ok(o_ok[3]), .err(o_err[3]));

    // Reference: reflected CRC-32 (0xEDB88320), returns the register before the final inversion
    function automatic logic [31:0] ref_reg(input logic [7:0] b [$]);
        logic [31:0] r;
        r = 32'hFFFFFFFF;
        foreach (b[i]) begin
            r = r ^ {24'h0, b[i]};
            for (int j = 0; j < 8; j++) begin
                r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = x[31-i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic drive(input int lane, input logic s, input logic e,
                         input logic [63:0] d, input logic [7:0] k);
        v[lane] = 1'b1; sop[lane] = s; eop[lane] = e;
        case (lane)
            0:       begin d0 = d[7:0];  k0 = k[0:0]; end
            1:       begin d1 = d[15:0]; k1 = k[1:0]; end
            2:       begin d2 = d[31:0]; k2 = k[3:0]; end
            default: begin d3 = d;       k3 = k;      end
        endcase
        @(posedge clk); #1;
        v[lane] = 1'b0; sop[lane] = 1'b0; eop[lane] = 1'b0;
    endtask

    // Packs bytes into beats of the lane's width; the scoreboard entry is pushed with the eop beat
    task automatic send_frame(input int lane, input logic [7:0] b [$], input logic [31:0] exp_fcs,
                              input logic exp_ok);
        int          w, n, pos, cnt;
        logic [63:0] d;
        logic [7:0]  k;
        exp_t        e;
        w = 1 << lane;
        n = b.size();
        pos = 0;
        while (pos < n) begin
            d = '0;
            k = '0;
            cnt = (n - pos > w) ? w : n - pos;
            for (int i = 0; i < cnt; i++) begin
                d[8*i +: 8] = b[pos+i];
                k[i] = 1'b1;
            end
            if (pos + cnt == n) begin
                e.lane = lane; e.fcs = exp_fcs; e.ok = exp_ok;
                sb.push_back(e);
            end
            drive(lane, pos == 0, pos + cnt == n, d, k);
            pos += cnt;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drain_left", sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    function automatic void digits(output logic [7:0] b [$], input int len);
        b = {};
        for (int i = 0; i < len; i++) b.push_back(8'h31 + 8'(i));
    endfunction

    // Monitor: pops the scoreboard on every out_valid and counts err pulses
    initial begin
        for (int l = 0; l < NL; l++) err_seen[l] = 0;
        forever begin
            @(negedge clk);
            cycle++;
            for (int l = 0; l < NL; l++) begin
                if (o_err[l]) err_seen[l]++;
                if (o_valid[l]) begin
                    ov_prev = ov_last;
                    ov_last = cycle;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out_valid lane %0d: got 1, required 0", l);
                    end else begin
                        mon_e = sb.pop_front();
                        chk("sb_lane", 32'(l), 32'(mon_e.lane));
                        chk("fcs_out", o_fcs[l], mon_e.fcs);
                        chk("fcs_ok", {31'h0, o_ok[l]}, {31'h0, mon_e.ok});
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  b [$];
        logic [31:0] r;
        int          e0;

        for (int l = 0; l < NL; l++)
            vecs.push_back('{lane: l, len: 9, append: 0, flip: 0, use_const: 1,
                             c_fcs: 32'hCBF43926, c_ok: 1'b0});
        vecs.push_back('{lane: 2, len: 9, append: 1, flip: 0, use_const: 1, c_fcs: 32'h2144DF1C, c_ok: 1'b1});
        vecs.push_back('{lane: 2, len: 9, append: 1, flip: 1, use_const: 0, c_fcs: 32'h0, c_ok: 1'b0});
        vecs.push_back('{lane: 3, len: 9, append: 1, flip: 0, use_const: 1, c_fcs: 32'h2144DF1C, c_ok: 1'b1});
        for (int len = 1; len <= 8; len++)
            vecs.push_back('{lane: 3, len: len, append: 0, flip: 0, use_const: 0, c_fcs: 32'h0, c_ok: 1'b0});
        for (int len = 1; len <= 3; len++)
            vecs.push_back('{lane: 1, len: len, append: 0, flip: 0, use_const: 0, c_fcs: 32'h0, c_ok: 1'b0});
        for (int len = 1; len <= 4; len++)
            vecs.push_back('{lane: 2, len: len, append: 0, flip: 0, use_const: 0, c_fcs: 32'h0, c_ok: 1'b0});

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        for (int l = 0; l < NL; l++) begin
            chk("reset_crc_state", o_crc[l], 32'hFFFFFFFF);
            chk("reset_out_valid", {31'h0, o_valid[l]}, 32'h0);
            chk("reset_fcs_out", o_fcs[l], 32'h0);
            chk("reset_fcs_ok", {31'h0, o_ok[l]}, 32'h0);
            chk("reset_err", {31'h0, o_err[l]}, 32'h0);
        end
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            digits(b, vecs[i].len);
            if (vecs[i].append) begin
                b.push_back(8'h26); b.push_back(8'h39); b.push_back(8'hF4); b.push_back(8'hCB);
            end
            if (vecs[i].flip) b[1] = b[1] ^ 8'h04;
            r = ref_reg(b);
            if (vecs[i].use_const) send_frame(vecs[i].lane, b, vecs[i].c_fcs, vecs[i].c_ok);
            else                   send_frame(vecs[i].lane, b, ~r, r == 32'hDEBB20E3);
            drain();
            chk("crc_state_after_frame", o_crc[vecs[i].lane], rev32(r));
            @(posedge clk); #1;
        end

        // Back-to-back: nine-digit frame then a single-byte sop&eop frame
        e0 = err_seen[2];
        digits(b, 9);
        send_frame(2, b, 32'hCBF43926, 1'b0);
        b = {8'h00};
        send_frame(2, b, 32'hD202EF8D, 1'b0);
        drain();
        chk("b2b_out_valid_spacing", 32'(ov_last - ov_prev), 32'd1);
        chk("b2b_no_err", 32'(err_seen[2]), 32'(e0));
        @(posedge clk); #1;

        // sop while in frame aborts the first frame
        e0 = err_seen[2];
        drive(2, 1'b1, 1'b0, 64'h44434241, 8'h0F);
        digits(b, 9);
        send_frame(2, b, 32'hCBF43926, 1'b0);
        drain();
        chk("sop_mid_frame_err", 32'(err_seen[2]), 32'(e0 + 1));
        @(posedge clk); #1;

        // Non-contiguous keep on eop drops the frame
        e0 = err_seen[2];
        drive(2, 1'b1, 1'b0, 64'h34333231, 8'h0F);
        drive(2, 1'b0, 1'b1, 64'h38373635, 8'h05);
        repeat (3) @(negedge clk);
        chk("bad_keep_err", 32'(err_seen[2]), 32'(e0 + 1));
        chk("bad_keep_crc_init", o_crc[2], 32'hFFFFFFFF);
        @(posedge clk); #1;

        // Partial keep on a non-eop beat also drops the frame
        e0 = err_seen[1];
        drive(1, 1'b1, 1'b0, 64'h3231, 8'h01);
        repeat (3) @(negedge clk);
        chk("short_non_eop_err", 32'(err_seen[1]), 32'(e0 + 1));
        @(posedge clk); #1;

        // Valid without sop in IDLE is ignored
        digits(b, 9);
        send_frame(2, b, 32'hCBF43926, 1'b0);
        drain();
        @(posedge clk); #1;
        e0 = err_seen[2];
        drive(2, 1'b0, 1'b0, 64'hDEADBEEF, 8'h0F);
        repeat (3) @(negedge clk);
        chk("no_sop_err", 32'(err_seen[2]), 32'(e0 + 1));
        chk("no_sop_crc_unchanged", o_crc[2], rev32(ref_reg(b)));
        @(posedge clk); #1;

        // Reset mid-frame, then a clean frame
        drive(2, 1'b1, 1'b0, 64'h34333231, 8'h0F);
        drive(2, 1'b0, 1'b0, 64'h38373635, 8'h0F);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midreset_crc_state", o_crc[2], 32'hFFFFFFFF);
        chk("midreset_out_valid", {31'h0, o_valid[2]}, 32'h0);
        chk("midreset_fcs_out", o_fcs[2], 32'h0);
        chk("midreset_fcs_ok", {31'h0, o_ok[2]}, 32'h0);
        @(posedge clk); #1;
        digits(b, 9);
        send_frame(2, b, 32'hCBF43926, 1'b0);
        drain();

        repeat (5) @(negedge clk);
        chk("final_scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
